bofs_block_sequencer: RTL and testbench



---
 rtl/bofs_block_sequencer_pkg.sv | 25 ++
 rtl/bofs_block_sequencer_expand.sv | 38 +++
 rtl/bofs_block_sequencer.sv | 178 +++++++++++++++++
 tb/tb_bofs_block_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bofs_block_sequencer_pkg.sv
// TauCfg: shared tile-accumulation config constants and types.
// Holds the block-sequencer state enum and the latched config bundle.
package TauCfg;

   localparam int WORK_BW = 16;
   localparam int VDIM    = 4;
   localparam int VSIZE   = 32;
   localparam int CV_BW   = $clog2(VSIZE);
   localparam int CCV_BW  = $clog2(CV_BW + 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef struct packed {
      logic [VDIM-1:0][WORK_BW-1:0]        bbegin;
      logic [VDIM-1:0][WORK_BW-1:0]        bend;
      logic [VDIM-1:0][WORK_BW-1:0]        bstride;
      logic [VDIM-1:0][WORK_BW-1:0]        bboundary;
      logic [VSIZE-1:0][VDIM-1:0][CV_BW-1:0] bsubofs;
      logic [VDIM-1:0][CCV_BW-1:0]         bsub_lo_order;
   } bofs_cfg_t;

endpackage

// File: rtl/bofs_block_sequencer_expand.sv
// Combinational block-offset expander: cursor -> per-lane offsets and mask.
module bofs_block_sequencer_expand #(
   parameter int WBW    = TauCfg::WORK_BW,
   parameter int VDIM   = TauCfg::VDIM,
   parameter int VSIZE  = TauCfg::VSIZE,
   parameter int CV_BW  = $clog2(VSIZE),
   parameter int CCV_BW = $clog2(CV_BW + 1)
) (
   input  logic [VDIM*WBW-1:0]         i_bofs,
   input  logic [VDIM*WBW-1:0]         i_bboundary,
   input  logic [VSIZE*VDIM*CV_BW-1:0] i_bsubofs,
   input  logic [VDIM*CCV_BW-1:0]      i_lo_order,
   output logic [VSIZE*VDIM*WBW-1:0]   o_vector_bofs,
   output logic [VSIZE-1:0]            o_lane_valid
);

   logic [WBW-1:0] w_sub;
   logic [WBW-1:0] w_v;

   always_comb begin
      o_vector_bofs = '0;
      o_lane_valid  = '1;
      w_sub         = '0;
      w_v           = '0;
      for (int i = 0; i < VSIZE; i++) begin
         for (int j = 0; j < VDIM; j++) begin
            w_sub = WBW'(i_bsubofs[(i*VDIM+j)*CV_BW +: CV_BW]);
            w_v   = i_bofs[j*WBW +: WBW]
                  | (w_sub << i_lo_order[j*CCV_BW +: CCV_BW]);
            o_vector_bofs[(i*VDIM+j)*WBW +: WBW] = w_v;
            // A lane survives only if it is inside the boundary on every dim
            if (!(i_bboundary[j*WBW +: WBW] > w_v))
               o_lane_valid[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/bofs_block_sequencer.sv
// Block-offset loop-nest sequencer: walks begin/end/stride per dim and
// emits one expanded lane-offset vector per step over valid/ready.
module bofs_block_sequencer #(
   parameter int WBW    = TauCfg::WORK_BW,
   parameter int VDIM   = TauCfg::VDIM,
   parameter int VSIZE  = TauCfg::VSIZE,
   parameter int CV_BW  = $clog2(VSIZE),
   parameter int CCV_BW = $clog2(CV_BW + 1)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_cfg_valid,
   output logic                         o_cfg_ready,
   input  logic [VDIM*WBW-1:0]          i_cfg_bbegin,
   input  logic [VDIM*WBW-1:0]          i_cfg_bend,
   input  logic [VDIM*WBW-1:0]          i_cfg_bstride,
   input  logic [VDIM*WBW-1:0]          i_cfg_bboundary,
   input  logic [VSIZE*VDIM*CV_BW-1:0]  i_cfg_bsubofs,
   input  logic [VDIM*CCV_BW-1:0]       i_cfg_bsub_lo_order,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [VDIM*WBW-1:0]          o_bofs,
   output logic [VSIZE*VDIM*WBW-1:0]    o_vector_bofs,
   output logic [VSIZE-1:0]             o_lane_valid,
   output logic                         o_last,
   output logic                         o_done
);

   TauCfg::state_t    r_state;
   TauCfg::state_t    w_state_nxt;
   TauCfg::bofs_cfg_t r_cfg;

   logic [VDIM-1:0][WBW-1:0] r_cursor;
   logic [VDIM-1:0][WBW-1:0] w_cursor_nxt;
   logic [WBW:0]             w_sum;
   logic                     w_carry;
   logic                     w_last;
   logic                     w_empty;
   logic                     w_accept;
   logic                     w_load;
   logic                     w_slot_free;

   logic [VSIZE*VDIM*WBW-1:0] w_vec;
   logic [VSIZE-1:0]          w_mask;

   logic                      r_valid;
   logic                      r_last;
   logic                      r_done;
   logic [VDIM*WBW-1:0]       r_bofs;
   logic [VSIZE*VDIM*WBW-1:0] r_vec;
   logic [VSIZE-1:0]          r_mask;

   assign w_slot_free = !r_valid || i_ready;

   always_comb begin
      w_empty = 1'b0;
      for (int j = 0; j < VDIM; j++)
         if (i_cfg_bbegin[j*WBW +: WBW] >= i_cfg_bend[j*WBW +: WBW])
            w_empty = 1'b1;
   end

   // Odometer: innermost dim steps first; sum kept at WBW+1 bits
   always_comb begin
      w_cursor_nxt = r_cursor;
      w_last       = 1'b1;
      w_carry      = 1'b1;
      w_sum        = '0;
      for (int j = VDIM - 1; j >= 0; j--) begin
         w_sum = {1'b0, r_cursor[j]} + {1'b0, r_cfg.bstride[j]};
         if (w_sum < {1'b0, r_cfg.bend[j]})
            w_last = 1'b0;
         if (w_carry) begin
            if (w_sum >= {1'b0, r_cfg.bend[j]}) begin
               w_cursor_nxt[j] = r_cfg.bbegin[j];
            end else begin
               w_cursor_nxt[j] = w_sum[WBW-1:0];
               w_carry         = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_cfg_ready = 1'b0;
      w_accept    = 1'b0;
      w_load      = 1'b0;
      unique case (r_state)
         TauCfg::IDLE: begin
            o_cfg_ready = 1'b1;
            if (i_cfg_valid) begin
               w_accept = 1'b1;
               if (!w_empty)
                  w_state_nxt = TauCfg::RUN;
            end
         end
         TauCfg::RUN: begin
            if (w_slot_free) begin
               w_load = 1'b1;
               if (w_last)
                  w_state_nxt = TauCfg::IDLE;
            end
         end
         default: w_state_nxt = TauCfg::IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_state <= TauCfg::IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cfg    <= '0;
         r_cursor <= '0;
      end else if (w_accept) begin
         r_cfg.bbegin        <= i_cfg_bbegin;
         r_cfg.bend          <= i_cfg_bend;
         r_cfg.bstride       <= i_cfg_bstride;
         r_cfg.bboundary     <= i_cfg_bboundary;
         r_cfg.bsubofs       <= i_cfg_bsubofs;
         r_cfg.bsub_lo_order <= i_cfg_bsub_lo_order;
         r_cursor            <= i_cfg_bbegin;
      end else if (w_load) begin
         r_cursor <= w_cursor_nxt;
      end
   end

   bofs_block_sequencer_expand #(
      .WBW    (WBW),
      .VDIM   (VDIM),
      .VSIZE  (VSIZE),
      .CV_BW  (CV_BW),
      .CCV_BW (CCV_BW)
   ) u_expand (
      .i_bofs        (r_cursor),
      .i_bboundary   (r_cfg.bboundary),
      .i_bsubofs     (r_cfg.bsubofs),
      .i_lo_order    (r_cfg.bsub_lo_order),
      .o_vector_bofs (w_vec),
      .o_lane_valid  (w_mask)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
         r_bofs  <= '0;
         r_vec   <= '0;
         r_mask  <= '0;
      end else begin
         r_done <= (w_accept && w_empty)
                 || (r_valid && i_ready && r_last);
         if (w_load) begin
            r_valid <= 1'b1;
            r_last  <= w_last;
            r_bofs  <= r_cursor;
            r_vec   <= w_vec;
            r_mask  <= w_mask;
         end else if (i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
      end
   end

   assign o_valid       = r_valid;
   assign o_last        = r_last;
   assign o_done        = r_done;
   assign o_bofs        = r_bofs;
   assign o_vector_bofs = r_vec;
   assign o_lane_valid  = r_mask;

endmodule

// File: tb/tb_bofs_block_sequencer.sv
// Directed bench for bofs_block_sequencer: walk, mask, stall, empty,
// overflow and mid-run reset.
module tb_bofs_block_sequencer;

   localparam int WBW    = 16;
   localparam int VDIM   = 4;
   localparam int VSIZE  = 32;
   localparam int CV_BW  = 5;
   localparam int CCV_BW = 3;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic                        cfg_valid = 1'b0;
   logic                        cfg_ready;
   logic [VDIM*WBW-1:0]         cfg_bbegin = '0;
   logic [VDIM*WBW-1:0]         cfg_bend = '0;
   logic [VDIM*WBW-1:0]         cfg_bstride = '0;
   logic [VDIM*WBW-1:0]         cfg_bboundary = '0;
   logic [VSIZE*VDIM*CV_BW-1:0] cfg_bsubofs = '0;
   logic [VDIM*CCV_BW-1:0]      cfg_lo = '0;
   logic                        valid;
   logic                        ready = 1'b1;
   logic [VDIM*WBW-1:0]         bofs;
   logic [VSIZE*VDIM*WBW-1:0]   vbofs;
   logic [VSIZE-1:0]            lane_valid;
   logic                        last;
   logic                        done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bofs_block_sequencer dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_cfg_valid         (cfg_valid),
      .o_cfg_ready         (cfg_ready),
      .i_cfg_bbegin        (cfg_bbegin),
      .i_cfg_bend          (cfg_bend),
      .i_cfg_bstride       (cfg_bstride),
      .i_cfg_bboundary     (cfg_bboundary),
      .i_cfg_bsubofs       (cfg_bsubofs),
      .i_cfg_bsub_lo_order (cfg_lo),
      .o_valid             (valid),
      .i_ready             (ready),
      .o_bofs              (bofs),
      .o_vector_bofs       (vbofs),
      .o_lane_valid        (lane_valid),
      .o_last              (last),
      .o_done              (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dim(input int j, input logic [15:0] b,
                          input logic [15:0] e, input logic [15:0] s,
                          input logic [15:0] bd);
      cfg_bbegin[j*WBW +: WBW]    = b;
      cfg_bend[j*WBW +: WBW]      = e;
      cfg_bstride[j*WBW +: WBW]   = s;
      cfg_bboundary[j*WBW +: WBW] = bd;
   endtask

   task automatic clear_cfg();
      for (int j = 0; j < VDIM; j++)
         set_dim(j, 16'd0, 16'd1, 16'd1, 16'hFFFF);
      cfg_bsubofs = '0;
      cfg_lo      = '0;
   endtask

   task automatic walk_cfg();
      clear_cfg();
      set_dim(2, 16'd0, 16'd8, 16'd4, 16'hFFFF);
      set_dim(3, 16'd0, 16'd64, 16'd32, 16'hFFFF);
   endtask

   task automatic send_cfg();
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   function automatic logic [15:0] d(input int j);
      return bofs[j*WBW +: WBW];
   endfunction

   function automatic logic [15:0] vb(input int i, input int j);
      return vbofs[(i*VDIM+j)*WBW +: WBW];
   endfunction

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_last", 64'(last), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_bofs", 64'(bofs), 64'd0);
      chk("rst_mask", 64'(lane_valid), 64'd0);
      chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      rst = 1'b0;
      tick();

      // basic walk
      walk_cfg();
      send_cfg();
      chk("walk_acc_valid", 64'(valid), 64'd0);
      chk("walk_acc_ready", 64'(cfg_ready), 64'd0);
      tick();
      chk("walk0_valid", 64'(valid), 64'd1);
      chk("walk0_bofs", 64'(bofs), 64'd0);
      chk("walk0_last", 64'(last), 64'd0);
      chk("walk0_mask", 64'(lane_valid), 64'hFFFF_FFFF);
      tick();
      chk("walk1_d2", 64'(d(2)), 64'd0);
      chk("walk1_d3", 64'(d(3)), 64'd32);
      chk("walk1_last", 64'(last), 64'd0);
      tick();
      chk("walk2_d2", 64'(d(2)), 64'd4);
      chk("walk2_d3", 64'(d(3)), 64'd0);
      chk("walk2_last", 64'(last), 64'd0);
      tick();
      chk("walk3_d2", 64'(d(2)), 64'd4);
      chk("walk3_d3", 64'(d(3)), 64'd32);
      chk("walk3_last", 64'(last), 64'd1);
      chk("walk3_done", 64'(done), 64'd0);
      tick();
      chk("walk_end_valid", 64'(valid), 64'd0);
      chk("walk_done", 64'(done), 64'd1);
      chk("walk_end_ready", 64'(cfg_ready), 64'd1);
      tick();
      chk("walk_done_clr", 64'(done), 64'd0);

      // lane mask
      clear_cfg();
      set_dim(0, 16'd0, 16'd1, 16'd1, 16'd1);
      set_dim(1, 16'd0, 16'd1, 16'd1, 16'd1);
      set_dim(2, 16'd0, 16'd1, 16'd1, 16'd8);
      set_dim(3, 16'd32, 16'd33, 16'd1, 16'd40);
      for (int i = 0; i < VSIZE; i++)
         cfg_bsubofs[(i*VDIM+3)*CV_BW +: CV_BW] = CV_BW'(i);
      send_cfg();
      tick();
      chk("mask_valid", 64'(valid), 64'd1);
      chk("mask_d3", 64'(d(3)), 64'd32);
      chk("mask_v0", 64'(vb(0, 3)), 64'd32);
      chk("mask_v7", 64'(vb(7, 3)), 64'd39);
      chk("mask_v31", 64'(vb(31, 3)), 64'd63);
      chk("mask_v31_d2", 64'(vb(31, 2)), 64'd0);
      chk("mask_lanes", 64'(lane_valid), 64'h0000_00FF);
      chk("mask_last", 64'(last), 64'd1);
      tick();
      chk("mask_done", 64'(done), 64'd1);
      tick();

      // backpressure
      walk_cfg();
      ready = 1'b0;
      send_cfg();
      tick();
      chk("bp0_valid", 64'(valid), 64'd1);
      chk("bp0_bofs", 64'(bofs), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_stall_valid", 64'(valid), 64'd1);
         chk("bp_stall_bofs", 64'(bofs), 64'd0);
         chk("bp_stall_last", 64'(last), 64'd0);
      end
      ready = 1'b1;
      tick();
      chk("bp1_d2", 64'(d(2)), 64'd0);
      chk("bp1_d3", 64'(d(3)), 64'd32);
      tick();
      chk("bp2_d2", 64'(d(2)), 64'd4);
      chk("bp2_d3", 64'(d(3)), 64'd0);
      tick();
      chk("bp3_d2", 64'(d(2)), 64'd4);
      chk("bp3_d3", 64'(d(3)), 64'd32);
      chk("bp3_last", 64'(last), 64'd1);
      tick();
      chk("bp_done", 64'(done), 64'd1);
      chk("bp_end_valid", 64'(valid), 64'd0);
      tick();

      // empty config
      walk_cfg();
      set_dim(2, 16'd8, 16'd8, 16'd4, 16'hFFFF);
      send_cfg();
      chk("empty_done", 64'(done), 64'd1);
      chk("empty_valid", 64'(valid), 64'd0);
      chk("empty_ready", 64'(cfg_ready), 64'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("empty_idle_valid", 64'(valid), 64'd0);
         chk("empty_idle_done", 64'(done), 64'd0);
         chk("empty_idle_ready", 64'(cfg_ready), 64'd1);
      end

      // overflow
      clear_cfg();
      set_dim(3, 16'hFFF0, 16'hFFFF, 16'h0020, 16'hFFFF);
      send_cfg();
      tick();
      chk("ovf_valid", 64'(valid), 64'd1);
      chk("ovf_d3", 64'(d(3)), 64'hFFF0);
      chk("ovf_last", 64'(last), 64'd1);
      tick();
      chk("ovf_end_valid", 64'(valid), 64'd0);
      chk("ovf_done", 64'(done), 64'd1);
      tick();
      chk("ovf_no_extra", 64'(valid), 64'd0);
      chk("ovf_ready", 64'(cfg_ready), 64'd1);

      // reset mid-run
      walk_cfg();
      send_cfg();
      tick();
      tick();
      chk("mr1_d3", 64'(d(3)), 64'd32);
      rst = 1'b1;
      tick();
      chk("mr_rst_valid", 64'(valid), 64'd0);
      chk("mr_rst_ready", 64'(cfg_ready), 64'd1);
      chk("mr_rst_done", 64'(done), 64'd0);
      rst = 1'b0;
      clear_cfg();
      set_dim(3, 16'd16, 16'd64, 16'd32, 16'hFFFF);
      send_cfg();
      tick();
      chk("mr_new0_bofs", 64'(bofs), 64'd16 << 48);
      chk("mr_new0_last", 64'(last), 64'd0);
      tick();
      chk("mr_new1_d3", 64'(d(3)), 64'd48);
      chk("mr_new1_last", 64'(last), 64'd1);
      tick();
      chk("mr_new_done", 64'(done), 64'd1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
